// File: rtl/branch_pkg.sv
// Shared branch-resolution types and helpers.
// funct3 codes, op-kind enum and immediate sign extension.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_BR,
    OP_JAL,
    OP_JALR
  } op_kind_e;

  // Sign-extend the low w bits of v to 32 bits.
  function automatic logic [31:0] sext32(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++)
      r[i] = (i < w) ? v[i] : v[5'(w - 1)];
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Branch condition comparator (combinational).
// Produces taken and illegal from funct3 and the two operands.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            taken,
  output logic            illegal
);

  // Evaluate the condition; unused encodings flag illegal.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (funct3)
      F3_BEQ:  taken = (op1 == op2);
      F3_BNE:  taken = (op1 != op2);
      F3_BLT:  taken = ($signed(op1) < $signed(op2));
      F3_BGE:  taken = ($signed(op1) >= $signed(op2));
      F3_BLTU: taken = (op1 < op2);
      F3_BGEU: taken = (op1 >= op2);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/JAL/JALR resolution stage with valid/ready.
// Optional BRANCH_STATS_EN adds saturating event counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 10,
  parameter int IMM_W     = 20,
  parameter int INST_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_b,
  input  logic              is_jal,
  input  logic              is_jalr,
  input  logic [2:0]        funct3,
  input  logic [IMM_W-1:0]  imm,
  input  logic [XLEN-1:0]   op1,
  input  logic [XLEN-1:0]   op2,
  input  logic [ADDR_W-1:0] address,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic [ADDR_W-1:0] target_address,
  output logic [ADDR_W-1:0] link_address,
  output logic              redirect,
  output logic              misaligned,
  output logic              illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_taken,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_STEP);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(INST_STEP - 1);

  op_kind_e          kind;
  logic              multi;
  logic              cmp_taken;
  logic              cmp_ill;
  logic [31:0]       imm32;
  logic [ADDR_W-1:0] imm_x;
  logic [ADDR_W-1:0] link;
  logic [ADDR_W-1:0] pc_tgt;
  logic [ADDR_W-1:0] jr_sum;
  logic [ADDR_W-1:0] jr_tgt;
  logic [ADDR_W-1:0] raw_tgt;
  logic [ADDR_W-1:0] c_target;
  logic              c_taken;
  logic              c_ill;
  logic              c_mis;
  logic              c_redir;
  logic              accept;
  logic              unused_imm;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign multi = (is_b & is_jal) | (is_b & is_jalr) |
                 (is_jal & is_jalr);

  assign imm32      = sext32(32'(imm), IMM_W);
  assign imm_x      = imm32[ADDR_W-1:0];
  assign unused_imm = ^imm32;
  assign link       = address + STEP;
  assign pc_tgt     = address + imm_x;
  assign jr_sum     = op1[ADDR_W-1:0] + imm_x;
  assign jr_tgt     = {jr_sum[ADDR_W-1:1], 1'b0};

  branch_cmp #(
    .XLEN(XLEN)
  ) u_cmp (
    .funct3 (funct3),
    .op1    (op1),
    .op2    (op2),
    .taken  (cmp_taken),
    .illegal(cmp_ill)
  );

  // Classify the op; multi-hot selects fall to NONE.
  always_comb begin
    kind = OP_NONE;
    unique case ({is_b, is_jal, is_jalr})
      3'b100:  kind = OP_BR;
      3'b010:  kind = OP_JAL;
      3'b001:  kind = OP_JALR;
      default: kind = OP_NONE;
    endcase
  end

  // Resolve decision, target and mispredict for this request.
  always_comb begin
    c_taken = 1'b0;
    c_ill   = multi;
    raw_tgt = pc_tgt;
    unique case (kind)
      OP_BR: begin
        c_taken = cmp_taken;
        c_ill   = cmp_ill;
      end
      OP_JAL:  c_taken = 1'b1;
      OP_JALR: begin
        c_taken = 1'b1;
        raw_tgt = jr_tgt;
      end
      default: ;
    endcase
    if (c_ill)
      c_taken = 1'b0;
    c_target = c_taken ? raw_tgt : link;
    c_mis    = c_taken && ((c_target & MASK) != '0);
    c_redir  = (c_taken != pred_taken) ||
               (c_taken && (pred_target != c_target));
    if (c_ill || c_mis)
      c_redir = 1'b0;
  end

  // Output register: flush beats accept, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      taken          <= 1'b0;
      target_address <= '0;
      link_address   <= '0;
      redirect       <= 1'b0;
      misaligned     <= 1'b0;
      illegal        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      taken          <= c_taken;
      target_address <= c_target;
      link_address   <= link;
      redirect       <= c_redir;
      misaligned     <= c_mis;
      illegal        <= c_ill;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BRANCH_STATS_EN
  logic is_ctl_q;
  logic hs;

  assign hs = out_valid && out_ready;

  // Remember whether the held result is a legal control op.
  always_ff @(posedge clk) begin
    if (rst)
      is_ctl_q <= 1'b0;
    else if (accept && !flush)
      is_ctl_q <= (kind != OP_NONE) && !c_ill;
  end

  // Saturating event counters, bumped on output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_taken       <= '0;
      stat_mispredicts <= '0;
    end else if (hs) begin
      if (is_ctl_q && stat_branches != '1)
        stat_branches <= stat_branches + 32'd1;
      if (taken && stat_taken != '1)
        stat_taken <= stat_taken + 32'd1;
      if (redirect && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: vector table,
// backpressure, flush/reset and a scoreboarded random stream.
module tb_branch_resolve_unit;

  typedef struct packed {
    logic        b;
    logic        jal;
    logic        jalr;
    logic [2:0]  f3;
    logic [19:0] imm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [9:0]  addr;
    logic        pt;
    logic [9:0]  ptg;
  } req_t;

  typedef struct packed {
    logic       tk;
    logic [9:0] tgt;
    logic [9:0] lnk;
    logic       rd;
    logic       mis;
    logic       ill;
  } res_t;

  typedef struct {
    req_t  rq;
    res_t  ex;
    string nm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        is_b, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [19:0] imm;
  logic [31:0] op1, op2;
  logic [9:0]  address;
  logic        pred_taken;
  logic [9:0]  pred_target;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [9:0]  target_address;
  logic [9:0]  link_address;
  logic        redirect;
  logic        misaligned;
  logic        illegal;
`ifdef BRANCH_STATS_EN
  logic [31:0] s_br, s_tk, s_mp;
`endif

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .is_b          (is_b),
    .is_jal        (is_jal),
    .is_jalr       (is_jalr),
    .funct3        (funct3),
    .imm           (imm),
    .op1           (op1),
    .op2           (op2),
    .address       (address),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .taken         (taken),
    .target_address(target_address),
    .link_address  (link_address),
    .redirect      (redirect),
    .misaligned    (misaligned),
    .illegal       (illegal)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches   (s_br),
    .stat_taken      (s_tk),
    .stat_mispredicts(s_mp)
`endif
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic req_t mkq(
    logic b, logic j, logic jr, logic [2:0] f3,
    logic [19:0] im, logic [31:0] a, logic [31:0] c,
    logic [9:0] ad, logic p, logic [9:0] pg);
    req_t r;
    r = {b, j, jr, f3, im, a, c, ad, p, pg};
    return r;
  endfunction

  function automatic res_t mkr(
    logic t, logic [9:0] g, logic [9:0] l,
    logic rd, logic ms, logic il);
    res_t r;
    r = {t, g, l, rd, ms, il};
    return r;
  endfunction

  function automatic res_t got();
    res_t r;
    r = {taken, target_address, link_address,
         redirect, misaligned, illegal};
    return r;
  endfunction

  task automatic drive(req_t r);
    is_b        = r.b;
    is_jal      = r.jal;
    is_jalr     = r.jalr;
    funct3      = r.f3;
    imm         = r.imm;
    op1         = r.op1;
    op2         = r.op2;
    address     = r.addr;
    pred_taken  = r.pt;
    pred_target = r.ptg;
  endtask

  // Reference model for the 10-bit address, step-4 build.
  function automatic res_t model(req_t r);
    res_t       e;
    int         n;
    logic [9:0] ix;
    logic [9:0] raw;
    logic       cond;
    n    = int'(r.b) + int'(r.jal) + int'(r.jalr);
    ix   = r.imm[9:0];
    e.lnk = r.addr + 10'd4;
    e.ill = (n > 1) || (r.b && n == 1 && r.f3[2:1] == 2'b01);
    case (r.f3)
      3'b000: cond = r.op1 == r.op2;
      3'b001: cond = r.op1 != r.op2;
      3'b100: cond = $signed(r.op1) < $signed(r.op2);
      3'b101: cond = $signed(r.op1) >= $signed(r.op2);
      3'b110: cond = r.op1 < r.op2;
      3'b111: cond = r.op1 >= r.op2;
      default: cond = 1'b0;
    endcase
    if (e.ill || n == 0)
      e.tk = 1'b0;
    else if (r.jal || r.jalr)
      e.tk = 1'b1;
    else
      e.tk = cond;
    if (r.jalr)
      raw = (r.op1[9:0] + ix) & 10'h3FE;
    else
      raw = r.addr + ix;
    e.tgt = e.tk ? raw : e.lnk;
    e.mis = e.tk && (e.tgt[1:0] != 2'b00);
    e.rd  = !e.ill && !e.mis &&
            ((e.tk != r.pt) || (e.tk && r.ptg != e.tgt));
    return e;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   k;
    k      = $urandom_range(0, 7);
    r.b    = (k <= 3) || (k == 7);
    r.jal  = (k == 4);
    r.jalr = (k == 5) || (k == 7);
    r.f3   = 3'($urandom_range(0, 7));
    r.imm  = 20'($urandom);
    r.op1  = $urandom;
    r.op2  = ($urandom_range(0, 1) == 1) ? r.op1 : $urandom;
    r.addr = 10'($urandom);
    r.pt   = 1'($urandom_range(0, 1));
    r.ptg  = ($urandom_range(0, 1) == 1) ?
             r.addr + r.imm[9:0] : 10'($urandom);
    return r;
  endfunction

  vec_t vecs[$];
  req_t bp1, bp2;
  res_t q[$];
  req_t cur;
  logic pend;
  int   sent, rcvd, cyc;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    drive('0);

    vecs.push_back('{mkq(1,0,0,3'b100,20'h00010,32'hFFFF_FFFF,1,10'h100,0,10'h000),
                     mkr(1,10'h110,10'h104,1,0,0), "blt"});
    vecs.push_back('{mkq(1,0,0,3'b110,20'h00010,32'hFFFF_FFFF,1,10'h100,0,10'h000),
                     mkr(0,10'h104,10'h104,0,0,0), "bltu"});
    vecs.push_back('{mkq(0,0,1,3'b000,20'hFFFFE,32'h123,0,10'h200,1,10'h120),
                     mkr(1,10'h120,10'h204,0,0,0), "jalr"});
    vecs.push_back('{mkq(1,0,0,3'b000,20'h00008,5,5,10'h3FC,1,10'h004),
                     mkr(1,10'h004,10'h000,0,0,0), "wrap"});
    vecs.push_back('{mkq(1,0,0,3'b010,20'h00010,5,5,10'h100,1,10'h110),
                     mkr(0,10'h104,10'h104,0,0,1), "f3_010"});
    vecs.push_back('{mkq(1,0,0,3'b001,20'h00002,1,2,10'h100,0,10'h000),
                     mkr(1,10'h102,10'h104,0,1,0), "misalign"});
    vecs.push_back('{mkq(0,1,0,3'b000,20'hFFFF0,0,0,10'h010,1,10'h000),
                     mkr(1,10'h000,10'h014,0,0,0), "jal_neg"});
    vecs.push_back('{mkq(0,1,0,3'b000,20'h00020,0,0,10'h040,1,10'h064),
                     mkr(1,10'h060,10'h044,1,0,0), "jal_badtgt"});
    vecs.push_back('{mkq(0,0,0,3'b000,20'h00008,0,0,10'h080,1,10'h000),
                     mkr(0,10'h084,10'h084,1,0,0), "none"});
    vecs.push_back('{mkq(1,1,0,3'b000,20'h00008,5,5,10'h080,1,10'h088),
                     mkr(0,10'h084,10'h084,0,0,1), "multi"});
    vecs.push_back('{mkq(1,0,0,3'b101,20'h00010,32'hFFFF_FFFF,1,10'h100,0,10'h000),
                     mkr(0,10'h104,10'h104,0,0,0), "bge"});
    vecs.push_back('{mkq(1,0,0,3'b111,20'h00010,32'hFFFF_FFFF,1,10'h100,1,10'h110),
                     mkr(1,10'h110,10'h104,0,0,0), "bgeu"});
    vecs.push_back('{mkq(1,0,0,3'b001,20'h00010,7,7,10'h100,1,10'h110),
                     mkr(0,10'h104,10'h104,1,0,0), "bne_eq"});
    vecs.push_back('{mkq(1,0,0,3'b011,20'h00010,1,2,10'h100,0,10'h000),
                     mkr(0,10'h104,10'h104,0,0,1), "f3_011"});
    vecs.push_back('{mkq(1,0,0,3'b100,20'hFFFFC,1,2,10'h000,0,10'h000),
                     mkr(1,10'h3FC,10'h004,1,0,0), "blt_back"});
    vecs.push_back('{mkq(0,0,1,3'b000,20'h00000,32'h105,0,10'h300,1,10'h104),
                     mkr(1,10'h104,10'h304,0,0,0), "jalr_bit0"});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out", {out_valid, got()}, '0);
    chk("reset_ready", in_ready, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rq);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk(vecs[i].nm, {out_valid, got()}, {1'b1, vecs[i].ex});
    end
    @(negedge clk);

    bp1 = mkq(1,0,0,3'b000,20'h00020,9,9,10'h100,1,10'h120);
    bp2 = mkq(1,0,0,3'b001,20'h00008,1,2,10'h200,0,10'h000);
    @(negedge clk);
    drive(bp1);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 drive(bp2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold", {out_valid, got()},
          {1'b1, mkr(1,10'h120,10'h104,0,0,0)});
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_release", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_next", {out_valid, got()},
        {1'b1, mkr(1,10'h208,10'h204,1,0,0)});
    @(negedge clk);
    @(negedge clk);

    drive(bp1);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_accept", out_valid, 0);

    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("flush_pre", out_valid, 1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flush_held", out_valid, 0);

    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mid", {out_valid, got()}, '0);
    chk("rst_mid_ready", in_ready, 1);

    pend = 1'b0;
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    cur  = '0;
    while (rcvd < 50 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!pend && sent < 50 && $urandom_range(0, 3) != 0) begin
        cur  = rand_req();
        pend = 1'b1;
      end
      drive(cur);
      in_valid  = pend;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL sb_extra: got %h want none", got());
        end else begin
          chk("sb", got(), q.pop_front());
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(cur));
        sent++;
        pend = 1'b0;
      end
    end
    chk("sb_count", rcvd, 50);
    chk("sb_left", q.size(), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

`ifdef BRANCH_STATS_EN
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      drive(mkq(1,0,0,3'b000,20'h00010,5,(i < 4) ? 5 : 6,
                10'h100,(i < 7),10'h110));
      in_valid  = 1'b1;
      out_ready = (i != 4);
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (i == 4) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("stat_stall", {s_br, s_tk, s_mp}, {32'd4, 32'd4, 32'd0});
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk("stat_final", {s_br, s_tk, s_mp}, {32'd10, 32'd4, 32'd3});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
